add64_seq_ctrl: RTL
===================

// Module: add64_seq_ctrl
// PURPOSE
//  Multi-cycle 64-bit add/subtract unit with a start/done handshake.
//  Operands are captured on start and summed one SLICE-bit slice per clock.
//  A registered carry links the slices; only one SLICE-wide adder exists.
//  Used where a single-cycle 64-bit ripple path misses timing.
//  Produces the sum plus carry, overflow and zero flags for downstream logic.
// PARAMETERS
//  WIDTH  64  operand/result width; must be a multiple of SLICE
//  SLICE  16  bits summed per cycle; NSLICE = WIDTH/SLICE (default 4)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous reset, active-high
//  start  in   1      request; sampled only in IDLE
//  sub    in   1      0: a+b+cin; 1: a+~b+1 (a-b; cin ignored)
//  a      in   WIDTH  operand A, captured on the accepted start edge
//  b      in   WIDTH  operand B, captured on the accepted start edge
//  cin    in   1      carry-in (add mode only)
//  busy   out  1      high in RUN
//  done   out  1      one-cycle pulse: results valid
//  s      out  WIDTH  sum, registered
//  cout   out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//  ovf    out  1      two's-complement signed overflow
//  zero   out  1      s == 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, s, cout, ovf, zero all 0; slice index 0.
//  Reset asserted mid-operation aborts it: no done, outputs cleared.
//  States:
//   IDLE -> RUN on start.
//   RUN -> DONE after NSLICE slice cycles.
//   DONE -> IDLE after one cycle.
//  Accept (edge k, IDLE, start=1):
//   latch A=a, B=sub ? ~b : b, C=sub ? 1 : cin.
//   Index=0; state=RUN.
//  RUN, edge k+1+i (i=0..NSLICE-1):
//   {C, s[i*SLICE +: SLICE]} = A slice + B slice + C.
//   Full-width unsigned add; carry out of each slice feeds the next.
//  Edge k+NSLICE:
//   cout=C.
//   ovf = (A[W-1]==B[W-1]) && (s[W-1]!=A[W-1]), using the inverted B in sub.
//   zero = (s==0) on the final sum.
//   State=DONE.
//  done=1 for exactly the cycle after edge k+NSLICE (latency NSLICE+1 clocks).
//  s/cout/ovf/zero hold until the next accepted start.
//  busy=1 during RUN only; 0 in IDLE and DONE.
//  start while RUN/DONE: ignored, not queued. Operand changes after accept: no effect.
//  start asserted in the DONE cycle is ignored; it must be re-presented in IDLE.
//  Back-to-back starts: at most one op per NSLICE+2 cycles.
//  s is overwritten slice by slice during RUN; it is valid only when done or idle after done.
// TESTING
//  1 a=1,b=1,cin=0,sub=0 -> done exactly 5 clocks after accept edge.
//    Expect s=2, cout=0, ovf=0, zero=0; busy high 4 cycles.
//  2 a=64'hFFFF_FFFF_FFFF_FFFF,b=0,cin=1 -> s=0, cout=1, zero=1, ovf=0.
//  3 a=64'h0000_0000_0000_FFFF,b=1 -> s=64'h0000_0000_0001_0000.
//    Checks slice-carry chaining.
//  4 a=64'h7FFF_FFFF_FFFF_FFFF,b=1 -> s=64'h8000_0000_0000_0000, ovf=1, cout=0.
//  5 sub=1,a=5,b=7 -> s=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//    sub=1,a=7,b=7 -> s=0, cout=1, zero=1.
//  6 start held during RUN -> single done.
//    rst pulsed at 2nd RUN cycle -> all outputs 0, no done.
//    Next start yields a correct result.

Source files
------------

// File: rtl/add64_seq_ctrl.sv
// Multi-cycle add/subtract unit: operands captured on start, summed one SLICE-wide
// slice per clock through a single adder with a registered inter-slice carry.
module add64_seq_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             c_q, c_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE:0]   slice_sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    slice_sum = {1'b0, a_q[idx_q*SLICE +: SLICE]}
              + {1'b0, b_q[idx_q*SLICE +: SLICE]}
              + (SLICE+1)'(c_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is folded into the add: B inverted, carry-in forced to 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        c_d   = slice_sum[SLICE];
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Flags are taken from the fully assembled next-state sum.
          cout_d  = slice_sum[SLICE];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (s_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
